// File: rtl/stack_ptr_unit.sv
// Downward-growing stack pointer with occupancy tracking, bounded push/pop/load,
// full/empty flags and sticky overflow/underflow errors.
module stack_ptr_unit #(
  parameter int unsigned     W        = 8,
  parameter logic [W-1:0]    EMPTY_SP = '0,
  parameter int unsigned     DEPTH    = 128,
  parameter int unsigned     STEP_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [W-1:0]      d_in,
  input  logic              push,
  input  logic              pop,
  input  logic [STEP_W-1:0] step,
  input  logic              err_clr,
  output logic [W-1:0]      sp,
  output logic [W-1:0]      rd_addr,
  output logic [W-1:0]      wr_addr,
  output logic [W-1:0]      occ,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [W:0]   DEPTH_X = (W+1)'(DEPTH);
  localparam logic [W-1:0] DEPTH_W = W'(DEPTH);

  logic [W-1:0] sp_nxt;
  logic [W-1:0] occ_nxt;
  logic [W-1:0] ld_occ;
  logic [W:0]   step_x;
  logic [W:0]   occ_after_push;
  logic         ovf_set;
  logic         unf_set;

  assign rd_addr = sp;
  assign wr_addr = sp - W'(1);
  assign occ     = EMPTY_SP - sp;

  assign ld_occ         = EMPTY_SP - d_in;
  assign step_x         = (W+1)'(step);
  // One extra bit so occ+step cannot wrap past DEPTH and look legal.
  assign occ_after_push = {1'b0, occ} + step_x;

  always_comb begin
    sp_nxt  = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ld) begin
      if ((W+1)'(ld_occ) <= DEPTH_X) sp_nxt = d_in;
      else                           ovf_set = 1'b1;
    end else if (push && pop) begin
      if (step_x > (W+1)'(occ)) unf_set = 1'b1;
    end else if (push) begin
      if (step != '0) begin
        if (occ_after_push <= DEPTH_X) sp_nxt = sp - W'(step);
        else                           ovf_set = 1'b1;
      end
    end else if (pop) begin
      if (step_x <= (W+1)'(occ)) sp_nxt = sp + W'(step);
      else                       unf_set = 1'b1;
    end
  end

  assign occ_nxt = EMPTY_SP - sp_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= EMPTY_SP;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      empty     <= (occ_nxt == '0);
      full      <= (occ_nxt == DEPTH_W);
      overflow  <= ovf_set | (overflow  & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

endmodule

// File: doc/stack_ptr_unit.md
# stack_ptr_unit

Parametrised stack-pointer unit for the CPU's call/return and push/pop datapath. It holds a W-bit stack pointer that grows downward from a configurable empty value. It tracks occupancy against a configurable depth and supports single- or multi-word push/pop (frame allocate/release) and direct load. Full/empty flags and sticky overflow/underflow errors are produced for the control unit, and push/pop addresses are presented to the scratch RAM.

## Interface
Parameters:
- W, 8, pointer and address width in bits.
- EMPTY_SP, 0, pointer value when the stack is empty; the first pushed item lands at EMPTY_SP-1 (mod 2^W).
- DEPTH, 128, maximum occupancy in words; legal range 1..2^W-1.
- STEP_W, 2, width of the push/pop step amount.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld  in  1  load sp from d_in.
- d_in  in  W  load value.
- push  in  1  move sp down by step.
- pop  in  1  move sp up by step.
- step  in  STEP_W  words to push/pop; 0 means no movement and no error.
- err_clr  in  1  clears overflow and underflow.
- sp  out  W  registered stack pointer (address of the top item).
- rd_addr  out  W  combinational, equals sp (pop/read address).
- wr_addr  out  W  combinational, equals sp-1 mod 2^W (single-word push address).
- occ  out  W  combinational occupancy, (EMPTY_SP - sp) mod 2^W.
- empty  out  1  registered, occ==0.
- full  out  1  registered, occ==DEPTH.
- overflow  out  1  registered sticky error.
- underflow  out  1  registered sticky error.

## Operation
- Priority per cycle: rst > ld > push/pop > hold.
- rst: sp=EMPTY_SP, empty=1, full=0, overflow=0, underflow=0. Reset has the same effect regardless of ld/push/pop/err_clr that cycle.
- ld, valid load (occupancy of d_in ≤ DEPTH): sp=d_in. Push/pop that cycle is ignored.
- ld, invalid load (occupancy of d_in > DEPTH): sp unchanged, overflow set.
- push only, step ≤ DEPTH-occ: sp = sp - step.
- push only, step > DEPTH-occ: sp unchanged, overflow set. No partial move.
- pop only, step ≤ occ: sp = sp + step.
- pop only, step > occ: sp unchanged, underflow set. No partial move.
- push and pop together (replace top): sp unchanged. If step > occ, underflow is set; otherwise there is no error.
- Arithmetic: all pointer math is mod 2^W. The headroom compare uses W+1-bit sums so occ+step never wraps.
- empty/full are recomputed from the next sp value, so they are always consistent with registered sp.
- err_clr clears overflow/underflow. If a new error occurs in the same cycle, the set wins.
- Errors never block later legal operations.

## Timing
- sp, empty, full, overflow and underflow update on the clock edge after the requesting cycle (1-cycle latency). There is no handshake; a request is accepted or rejected in that single cycle.
- rd_addr, wr_addr and occ are combinational from registered sp. A push writes RAM at wr_addr in the same cycle push is asserted. A pop reads rd_addr before the edge.
- Wrap-around:
  - With EMPTY_SP=0, the first push moves sp 0x00 to 0xFF.
  - Popping back to empty wraps 0xFF to 0x00.
  - Neither wrap is an error.
- A reset asserted mid-sequence aborts the sequence; the next cycle shows reset values only.

## Test plan
Parameters W=8, EMPTY_SP=0, DEPTH=4, STEP_W=2.
- Reset then single push: rst -> sp=0x00, empty=1, full=0, errors 0. push, step=1 with wr_addr=0xFF during the push -> sp=0xFF, empty=0, occ=1.
- Fill and overflow: from empty, 4 single pushes -> sp=0xFC, full=1. A 5th push -> sp stays 0xFC, overflow=1. err_clr -> overflow=0. err_clr plus another push the same cycle -> overflow stays 1.
- Underflow: from empty, pop step=1 -> sp=0x00, underflow=1, empty=1. Then push step=1 -> sp=0xFF; a subsequent pop returns sp=0x00.
- Multi-step:
  - At occ=2 (sp=0xFE), push step=3 -> sp=0xFE, overflow=1.
  - Push step=2 -> sp=0xFC, full=1.
  - Pop step=3 -> sp=0xFF.
  - Pop step=2 -> sp unchanged, underflow=1.
- Load and priority:
  - ld d_in=0xFE -> sp=0xFE, occ=2.
  - ld d_in=0x10 -> sp unchanged, overflow=1.
  - ld=0xFD together with push step=1 -> sp=0xFD.
  - push+pop together at occ=3 -> sp unchanged, no error.
- Reset mid-operation: at sp=0xFD, rst together with push and err_clr -> next cycle sp=0x00, empty=1, full=0, overflow=0, underflow=0.
